// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage:
// ALUOp, ALU control, funct codes and control-bundle bit positions.
package mips_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ADDI  = 2'b11;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_ctl_e;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;
   localparam int MEM_BRANCH  = 2;
   localparam int MEM_READ    = 1;
   localparam int MEM_WRITE   = 0;
   localparam int EX_REGDST   = 3;
   localparam int EX_ALUSRC   = 2;
   localparam int EX_OP_MSB   = 1;
   localparam int EX_OP_LSB   = 0;

   typedef enum logic [1:0] {
      FWD_RAW   = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-hazard forwarding select; the EX/MEM source
// always beats MEM/WB and register $0 never forwards.
module fwd_unit
   import mips_pkg::*;
#(
   parameter int FWD_EN = 1
) (
   input  logic [4:0] rs_idx,
   input  logic [4:0] rt_idx,
   input  logic       exmem_regwrite,
   input  logic [4:0] exmem_rd,
   input  logic       memwb_regwrite,
   input  logic [4:0] memwb_rd,
   output fwd_sel_e   fwd_a,
   output fwd_sel_e   fwd_b
);

   logic ex_a, ex_b, wb_a, wb_b;

   assign ex_a = (FWD_EN != 0) && exmem_regwrite
              && (exmem_rd == rs_idx) && (rs_idx != 5'd0);
   assign ex_b = (FWD_EN != 0) && exmem_regwrite
              && (exmem_rd == rt_idx) && (rt_idx != 5'd0);
   assign wb_a = (FWD_EN != 0) && memwb_regwrite && !ex_a
              && (memwb_rd == rs_idx) && (rs_idx != 5'd0);
   assign wb_b = (FWD_EN != 0) && memwb_regwrite && !ex_b
              && (memwb_rd == rt_idx) && (rt_idx != 5'd0);

   always_comb begin
      fwd_a = FWD_RAW;
      fwd_b = FWD_RAW;
      unique case (1'b1)
         ex_a:    fwd_a = FWD_EXMEM;
         wb_a:    fwd_a = FWD_MEMWB;
         default: fwd_a = FWD_RAW;
      endcase
      unique case (1'b1)
         ex_b:    fwd_b = FWD_EXMEM;
         wb_b:    fwd_b = FWD_MEMWB;
         default: fwd_b = FWD_RAW;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control, ALU, branch target,
// forwarding and the EX/MEM pipeline register.
module ex_stage
   import mips_pkg::*;
#(
   parameter int DW     = 32,
   parameter int FWD_EN = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic [1:0]    wb_in,
   input  logic [2:0]    mem_in,
   input  logic [3:0]    ex_in,
   input  logic [DW-1:0] npc,
   input  logic [DW-1:0] readdat1,
   input  logic [DW-1:0] readdat2,
   input  logic [DW-1:0] sign_ext,
   input  logic [4:0]    rs_idx,
   input  logic [4:0]    rt_idx,
   input  logic [4:0]    rd_idx,
   input  logic          memwb_regwrite,
   input  logic [4:0]    memwb_rd,
   input  logic [DW-1:0] memwb_wdata,
   output logic [1:0]    wb_out,
   output logic [2:0]    mem_out,
   output logic [DW-1:0] branch_target,
   output logic          zero,
   output logic [DW-1:0] alu_result,
   output logic [DW-1:0] store_data,
   output logic [4:0]    dest_reg
);

   alu_ctl_e      alu_ctl;
   fwd_sel_e      fwd_a, fwd_b;
   logic [DW-1:0] op_a, rt_val, op_b, alu_y, br_tgt;
   logic [4:0]    dst;

   // EX/MEM source is the registered output, so a held
   // (stalled) result is what gets forwarded.
   fwd_unit #(.FWD_EN(FWD_EN)) u_fwd (
      .rs_idx         (rs_idx),
      .rt_idx         (rt_idx),
      .exmem_regwrite (wb_out[WB_REGWRITE]),
      .exmem_rd       (dest_reg),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b)
   );

   always_comb begin
      alu_ctl = ALU_ADD;
      unique case (ex_in[EX_OP_MSB:EX_OP_LSB])
         ALUOP_SUB: alu_ctl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (sign_ext[5:0])
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_SLT:  alu_ctl = ALU_SLT;
               default: alu_ctl = ALU_ADD;
            endcase
         end
         default: alu_ctl = ALU_ADD;
      endcase
   end

   always_comb begin
      op_a = readdat1;
      unique case (fwd_a)
         FWD_EXMEM: op_a = alu_result;
         FWD_MEMWB: op_a = memwb_wdata;
         default:   op_a = readdat1;
      endcase
      rt_val = readdat2;
      unique case (fwd_b)
         FWD_EXMEM: rt_val = alu_result;
         FWD_MEMWB: rt_val = memwb_wdata;
         default:   rt_val = readdat2;
      endcase
      op_b = ex_in[EX_ALUSRC] ? sign_ext : rt_val;
   end

   always_comb begin
      alu_y = op_a + op_b;
      unique case (alu_ctl)
         ALU_AND: alu_y = op_a & op_b;
         ALU_OR:  alu_y = op_a | op_b;
         ALU_SUB: alu_y = op_a - op_b;
         ALU_SLT: alu_y = {{(DW-1){1'b0}},
                           $signed(op_a) < $signed(op_b)};
         default: alu_y = op_a + op_b;
      endcase
   end

   assign br_tgt = npc + (sign_ext << 2);
   assign dst    = ex_in[EX_REGDST] ? rd_idx : rt_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_out        <= '0;
         mem_out       <= '0;
         branch_target <= '0;
         zero          <= 1'b0;
         alu_result    <= '0;
         store_data    <= '0;
         dest_reg      <= '0;
      end else if (flush || !stall) begin
         wb_out        <= flush ? 2'b00 : wb_in;
         mem_out       <= flush ? 3'b000 : mem_in;
         branch_target <= br_tgt;
         zero          <= (alu_y == '0);
         alu_result    <= alu_y;
         store_data    <= rt_val;
         dest_reg      <= dst;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for the MIPS execute stage.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [1:0]  wb_in;
   logic [2:0]  mem_in;
   logic [3:0]  ex_in;
   logic [31:0] npc, readdat1, readdat2, sign_ext;
   logic [4:0]  rs_idx, rt_idx, rd_idx;
   logic        memwb_regwrite;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_wdata;
   logic [1:0]  wb_out;
   logic [2:0]  mem_out;
   logic [31:0] branch_target, alu_result, store_data;
   logic        zero;
   logic [4:0]  dest_reg;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ex_stage #(.DW(32), .FWD_EN(1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .wb_in(wb_in), .mem_in(mem_in), .ex_in(ex_in),
      .npc(npc), .readdat1(readdat1), .readdat2(readdat2),
      .sign_ext(sign_ext), .rs_idx(rs_idx), .rt_idx(rt_idx),
      .rd_idx(rd_idx), .memwb_regwrite(memwb_regwrite),
      .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
      .wb_out(wb_out), .mem_out(mem_out),
      .branch_target(branch_target), .zero(zero),
      .alu_result(alu_result), .store_data(store_data),
      .dest_reg(dest_reg)
   );

   task automatic drive(input logic [1:0] wb, input logic [2:0] mem,
                        input logic [3:0] ex, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
      wb_in = wb; mem_in = mem; ex_in = ex;
      readdat1 = a; readdat2 = b; sign_ext = imm; npc = pc;
      rs_idx = rs; rt_idx = rt; rd_idx = rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_wdata = 32'd0;
      drive(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
      #2;
      n_cmp++; if ({wb_out, mem_out, zero, dest_reg} !== 11'd0) begin n_bad++; $display("FAIL reset_ctl: got %h want 0", {wb_out, mem_out, zero, dest_reg}); end
      n_cmp++; if ({alu_result, branch_target, store_data} !== 96'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {alu_result, branch_target, store_data}); end
      rst = 1'b0;
      drive(2'b10, 3'b001, 4'b1010, 32'h12, 32'h34, 32'h20, 32'h4, 1, 2, 3);
      step();
      n_cmp++; if (alu_result !== 32'h46) begin n_bad++; $display("FAIL pre_rst_alu: got %h want %h", alu_result, 32'h46); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({wb_out, mem_out, dest_reg} !== 10'd0) begin n_bad++; $display("FAIL async_rst_ctl: got %h want 0", {wb_out, mem_out, dest_reg}); end
      n_cmp++; if ({alu_result, branch_target, store_data} !== 96'd0) begin n_bad++; $display("FAIL async_rst_data: got %h want 0", {alu_result, branch_target, store_data}); end
      rst = 1'b0;
      step();
      n_cmp++; if (alu_result !== 32'h46) begin n_bad++; $display("FAIL post_rst_alu: got %h want %h", alu_result, 32'h46); end
      n_cmp++; if (branch_target !== 32'h84) begin n_bad++; $display("FAIL post_rst_bt: got %h want %h", branch_target, 32'h84); end
      n_cmp++; if ({wb_out, mem_out, dest_reg} !== {2'b10, 3'b001, 5'd3}) begin n_bad++; $display("FAIL post_rst_ctl: got %h want %h", {wb_out, mem_out, dest_reg}, {2'b10, 3'b001, 5'd3}); end
   endtask

   task automatic test_rtype();
      drive(2'b10, 3'b000, 4'b1010, 32'd7, 32'd3, 32'h22, 0, 8, 9, 10);
      step();
      n_cmp++; if (alu_result !== 32'd4) begin n_bad++; $display("FAIL sub_alu: got %h want %h", alu_result, 32'd4); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL sub_zero: got %b want 0", zero); end
      n_cmp++; if (dest_reg !== 5'd10) begin n_bad++; $display("FAIL sub_dest: got %0d want 10", dest_reg); end
      n_cmp++; if (store_data !== 32'd3) begin n_bad++; $display("FAIL sub_store: got %h want 3", store_data); end
      drive(2'b10, 3'b000, 4'b0010, 32'hF0, 32'h3C, 32'h24, 0, 8, 9, 10);
      step();
      n_cmp++; if (alu_result !== 32'h30) begin n_bad++; $display("FAIL and_alu: got %h want %h", alu_result, 32'h30); end
      n_cmp++; if (dest_reg !== 5'd9) begin n_bad++; $display("FAIL and_dest_rt: got %0d want 9", dest_reg); end
      drive(2'b10, 3'b000, 4'b1010, 32'hF0, 32'h0F, 32'h25, 0, 11, 12, 13);
      step();
      n_cmp++; if (alu_result !== 32'hFF) begin n_bad++; $display("FAIL or_alu: got %h want %h", alu_result, 32'hFF); end
      drive(2'b10, 3'b000, 4'b1010, 32'hF0, 32'h10, 32'h26, 0, 11, 12, 13);
      step();
      n_cmp++; if (alu_result !== 32'h100) begin n_bad++; $display("FAIL badfn_add: got %h want %h", alu_result, 32'h100); end
   endtask

   task automatic test_branch();
      drive(2'b00, 3'b100, 4'b0001, 32'd5, 32'd5, 32'd3, 32'h100, 5, 6, 0);
      step();
      n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL beq_zero: got %b want 1", zero); end
      n_cmp++; if (branch_target !== 32'h10C) begin n_bad++; $display("FAIL beq_target: got %h want %h", branch_target, 32'h10C); end
      n_cmp++; if ({wb_out, mem_out} !== 5'b00100) begin n_bad++; $display("FAIL beq_ctl: got %b want 00100", {wb_out, mem_out}); end
      drive(2'b00, 3'b100, 4'b0001, 32'd1, 32'd0, 32'd2, 32'hFFFF_FFFC, 5, 6, 0);
      step();
      n_cmp++; if (branch_target !== 32'h4) begin n_bad++; $display("FAIL bt_wrap: got %h want %h", branch_target, 32'h4); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL bne_zero: got %b want 0", zero); end
      drive(2'b00, 3'b100, 4'b0001, 32'd1, 32'd0, 32'hFFFF_FFFC, 32'h100, 5, 6, 0);
      step();
      n_cmp++; if (branch_target !== 32'hF0) begin n_bad++; $display("FAIL bt_neg: got %h want %h", branch_target, 32'hF0); end
   endtask

   task automatic test_back_to_back();
      drive(2'b10, 3'b000, 4'b1010, 32'd10, 32'd20, 32'h20, 0, 2, 3, 1);
      step();
      n_cmp++; if (alu_result !== 32'd30) begin n_bad++; $display("FAIL b2b_add: got %h want %h", alu_result, 32'd30); end
      drive(2'b10, 3'b000, 4'b1010, 32'h55, 32'h55, 32'h22, 0, 1, 1, 2);
      memwb_regwrite = 1'b1; memwb_rd = 5'd1; memwb_wdata = 32'h77;
      step();
      n_cmp++; if (alu_result !== 32'd0) begin n_bad++; $display("FAIL b2b_exmem_win: got %h want 0", alu_result); end
      n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL b2b_zero: got %b want 1", zero); end
      n_cmp++; if (store_data !== 32'd30) begin n_bad++; $display("FAIL b2b_store: got %h want %h", store_data, 32'd30); end
      drive(2'b10, 3'b000, 4'b1010, 32'h55, 32'd5, 32'h20, 0, 1, 4, 3);
      step();
      n_cmp++; if (alu_result !== 32'h7C) begin n_bad++; $display("FAIL memwb_fwd: got %h want %h", alu_result, 32'h7C); end
      drive(2'b10, 3'b000, 4'b1010, 32'h11, 32'h22, 32'h20, 0, 5, 6, 0);
      memwb_rd = 5'd0; memwb_wdata = 32'h99;
      step();
      n_cmp++; if (alu_result !== 32'h33) begin n_bad++; $display("FAIL wr_r0_alu: got %h want %h", alu_result, 32'h33); end
      drive(2'b10, 3'b000, 4'b1010, 32'd0, 32'd0, 32'h20, 0, 0, 0, 7);
      step();
      n_cmp++; if (alu_result !== 32'd0) begin n_bad++; $display("FAIL r0_no_fwd: got %h want 0", alu_result); end
      memwb_regwrite = 1'b0;
   endtask

   task automatic test_slt_lw();
      drive(2'b10, 3'b000, 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'h2A, 0, 13, 14, 16);
      step();
      n_cmp++; if (alu_result !== 32'd1) begin n_bad++; $display("FAIL slt_neg: got %h want 1", alu_result); end
      drive(2'b10, 3'b000, 4'b1010, 32'd1, 32'hFFFF_FFFF, 32'h2A, 0, 13, 14, 16);
      step();
      n_cmp++; if ({alu_result, zero} !== {32'd0, 1'b1}) begin n_bad++; $display("FAIL slt_pos: got %h want %h", {alu_result, zero}, {32'd0, 1'b1}); end
      drive(2'b11, 3'b010, 4'b0100, 32'h1000, 32'hABCD, 32'hFFFF_FFFC, 0, 13, 15, 0);
      step();
      n_cmp++; if (alu_result !== 32'h0FFC) begin n_bad++; $display("FAIL lw_addr: got %h want %h", alu_result, 32'h0FFC); end
      n_cmp++; if ({dest_reg, wb_out, mem_out} !== {5'd15, 2'b11, 3'b010}) begin n_bad++; $display("FAIL lw_ctl: got %h want %h", {dest_reg, wb_out, mem_out}, {5'd15, 2'b11, 3'b010}); end
      n_cmp++; if (store_data !== 32'hABCD) begin n_bad++; $display("FAIL lw_store: got %h want %h", store_data, 32'hABCD); end
      drive(2'b11, 3'b010, 4'b0111, 32'h10, 32'd0, 32'h22, 0, 17, 18, 0);
      step();
      n_cmp++; if (alu_result !== 32'h32) begin n_bad++; $display("FAIL aluop11_add: got %h want %h", alu_result, 32'h32); end
   endtask

   task automatic test_stall_flush();
      drive(2'b10, 3'b001, 4'b1010, 32'h30, 32'h5, 32'h20, 32'h40, 20, 21, 22);
      step();
      drive(2'b01, 3'b100, 4'b1010, 32'd1, 32'd2, 32'h22, 0, 20, 21, 23);
      stall = 1'b1;
      step();
      step();
      n_cmp++; if (alu_result !== 32'h35) begin n_bad++; $display("FAIL stall_alu: got %h want %h", alu_result, 32'h35); end
      n_cmp++; if ({wb_out, mem_out, dest_reg, zero} !== {2'b10, 3'b001, 5'd22, 1'b0}) begin n_bad++; $display("FAIL stall_ctl: got %h want %h", {wb_out, mem_out, dest_reg, zero}, {2'b10, 3'b001, 5'd22, 1'b0}); end
      n_cmp++; if ({branch_target, store_data} !== {32'hC0, 32'h5}) begin n_bad++; $display("FAIL stall_data: got %h want %h", {branch_target, store_data}, {32'hC0, 32'h5}); end
      drive(2'b10, 3'b001, 4'b1010, 32'h100, 32'h200, 32'h20, 0, 24, 25, 17);
      flush = 1'b1;
      step();
      n_cmp++; if ({wb_out, mem_out} !== 5'd0) begin n_bad++; $display("FAIL flush_stall_ctl: got %b want 00000", {wb_out, mem_out}); end
      stall = 1'b0; flush = 1'b0;
      drive(2'b10, 3'b000, 4'b1010, 32'd5, 32'd6, 32'h20, 0, 17, 18, 19);
      step();
      n_cmp++; if (alu_result !== 32'hB) begin n_bad++; $display("FAIL bubble_no_fwd: got %h want %h", alu_result, 32'hB); end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_branch();
      test_back_to_back();
      test_slt_lw();
      test_stall_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
